// File: rtl/polynomial_evaluate.sv
// polynomial_evaluate: evaluates a polynomial over the prime field at
// x = 0..nevals-1 using Horner's rule on one serial multiplier and one adder.
//
// Ports:
//   clk          clock, all state updates on posedge
//   rstb         asynchronous active-low reset
//   en           start request, honoured only while ready is high
//   c            npoints coefficients, c[j] multiplies x^j
//   y_wren       one-cycle strobe, y_data holds p(x)
//   y_data       p(x) mod prime for the current x
//   ready        idle, able to accept en
//   ready_pulse  one-cycle pulse after the last evaluation
//
// The field prime is assumed to satisfy prime > 2^(F_NBITS-1), so any
// F_NBITS-bit value and any sum of two reduced values needs at most one
// conditional subtraction to become fully reduced.

`ifndef F_NBITS
`define F_NBITS 61
`endif
`ifndef F_PRIME
`define F_PRIME 61'h1FFF_FFFF_FFFF_FFFF
`endif

// field_multiplier: bit-serial (a * b) mod prime, MSB first.
// Latches a/b on start, pulses done after nbits steps.
// Cycle count is fixed, independent of the operand values.
module field_multiplier #(
    parameter int               nbits = `F_NBITS,
    parameter logic [nbits-1:0] prime = `F_PRIME
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             start,
    input  logic [nbits-1:0] a,
    input  logic [nbits-1:0] b,
    output logic [nbits-1:0] prod,
    output logic             done
);
    localparam int cw = $clog2(nbits + 1);

    logic [nbits-1:0] a_q;
    logic [nbits-1:0] b_q;
    logic [cw-1:0]    cnt;
    logic             busy;

    function automatic logic [nbits-1:0] reduce(
        input logic [nbits:0] v
    );
        logic [nbits:0] pz;
        logic [nbits:0] d;
        pz = {1'b0, prime};
        d  = v - pz;
        if (v >= pz) return d[nbits-1:0];
        return v[nbits-1:0];
    endfunction

    // One double-and-add step: r = 2r (+ addend) mod prime.
    function automatic logic [nbits-1:0] step(
        input logic [nbits-1:0] r,
        input logic [nbits-1:0] addend,
        input logic             sel
    );
        logic [nbits-1:0] dbl;
        dbl = reduce({r, 1'b0});
        if (sel) return reduce({1'b0, dbl} + {1'b0, addend});
        return dbl;
    endfunction

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            a_q  <= '0;
            b_q  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            prod <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                a_q  <= a;
                b_q  <= b;
                cnt  <= cw'(nbits);
                busy <= 1'b1;
                prod <= '0;
            end else if (busy) begin
                prod <= step(prod, a_q, b_q[nbits-1]);
                b_q  <= b_q << 1;
                cnt  <= cnt - 1'b1;
                if (cnt == cw'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end
endmodule

// field_adder: registered (a + b) mod prime, done one cycle after start.
module field_adder #(
    parameter int               nbits = `F_NBITS,
    parameter logic [nbits-1:0] prime = `F_PRIME
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             start,
    input  logic [nbits-1:0] a,
    input  logic [nbits-1:0] b,
    output logic [nbits-1:0] sum,
    output logic             done
);
    logic [nbits:0] raw;
    logic [nbits:0] sub;

    assign raw = {1'b0, a} + {1'b0, b};
    assign sub = raw - {1'b0, prime};

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            sum  <= '0;
            done <= 1'b0;
        end else begin
            done <= start;
            if (start) begin
                if (raw >= {1'b0, prime}) sum <= sub[nbits-1:0];
                else                      sum <= raw[nbits-1:0];
            end
        end
    end
endmodule

module polynomial_evaluate #(
    parameter int                   npoints = 9,
    parameter int                   nevals  = npoints,
    parameter logic [`F_NBITS-1:0]  prime   = `F_PRIME
) (
    input  logic                               clk,
    input  logic                               rstb,
    input  logic                               en,
    input  logic [npoints-1:0][`F_NBITS-1:0]   c,
    output logic                               y_wren,
    output logic [`F_NBITS-1:0]                y_data,
    output logic                               ready,
    output logic                               ready_pulse
);
    localparam int nb = `F_NBITS;
    localparam int xw = $clog2(nevals + 1);
    localparam int jw = (npoints > 1) ? $clog2(npoints) : 1;
    localparam logic [xw-1:0] x_last = xw'(nevals - 1);
    localparam logic [jw-1:0] j_top  =
        jw'((npoints > 1) ? npoints - 2 : 0);

    typedef enum logic [2:0] {
        s_idle,
        s_load,
        s_mul,
        s_add,
        s_emit,
        s_done
    } state_t;

    state_t                    state;
    logic [npoints-1:0][nb-1:0] creg;
    logic [nb-1:0]             acc;
    logic [xw-1:0]             x;
    logic [jw-1:0]             j;
    logic                      mul_start;
    logic                      mul_done;
    logic [nb-1:0]             mul_prod;
    logic                      add_start;
    logic                      add_done;
    logic [nb-1:0]             add_sum;
    logic [nb-1:0]             lead;
    logic [nb:0]               lead_sub;

    // Coefficients are not required to arrive reduced; the leading one is
    // reduced here, the others are reduced on their way through the adder.
    assign lead_sub = {1'b0, creg[npoints-1]} - {1'b0, prime};
    assign lead = (creg[npoints-1] >= prime) ? lead_sub[nb-1:0]
                                             : creg[npoints-1];

    field_multiplier #(
        .nbits (nb),
        .prime (prime)
    ) u_mul (
        .clk   (clk),
        .rstb  (rstb),
        .start (mul_start),
        .a     (acc),
        .b     ({{(nb - xw){1'b0}}, x}),
        .prod  (mul_prod),
        .done  (mul_done)
    );

    field_adder #(
        .nbits (nb),
        .prime (prime)
    ) u_add (
        .clk   (clk),
        .rstb  (rstb),
        .start (add_start),
        .a     (acc),
        .b     (creg[j]),
        .sum   (add_sum),
        .done  (add_done)
    );

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state       <= s_idle;
            ready       <= 1'b1;
            ready_pulse <= 1'b0;
            y_wren      <= 1'b0;
            y_data      <= '0;
            x           <= '0;
            j           <= '0;
            acc         <= '0;
            creg        <= '0;
            mul_start   <= 1'b0;
            add_start   <= 1'b0;
        end else begin
            mul_start   <= 1'b0;
            add_start   <= 1'b0;
            y_wren      <= 1'b0;
            ready_pulse <= 1'b0;
            unique case (state)
                s_idle: begin
                    if (en) begin
                        creg  <= c;
                        x     <= '0;
                        ready <= 1'b0;
                        state <= s_load;
                    end
                end
                s_load: begin
                    acc <= lead;
                    j   <= j_top;
                    if (npoints == 1) begin
                        y_wren <= 1'b1;
                        y_data <= lead;
                        state  <= s_emit;
                    end else begin
                        mul_start <= 1'b1;
                        state     <= s_mul;
                    end
                end
                s_mul: begin
                    if (mul_done) begin
                        acc       <= mul_prod;
                        add_start <= 1'b1;
                        state     <= s_add;
                    end
                end
                s_add: begin
                    if (add_done) begin
                        acc <= add_sum;
                        if (j == '0) begin
                            y_wren <= 1'b1;
                            y_data <= add_sum;
                            state  <= s_emit;
                        end else begin
                            j         <= j - 1'b1;
                            mul_start <= 1'b1;
                            state     <= s_mul;
                        end
                    end
                end
                s_emit: begin
                    if (x == x_last) begin
                        ready_pulse <= 1'b1;
                        ready       <= 1'b1;
                        state       <= s_done;
                    end else begin
                        x     <= x + 1'b1;
                        state <= s_load;
                    end
                end
                s_done: begin
                    // A start request here chains straight into a new run.
                    if (en) begin
                        creg  <= c;
                        x     <= '0;
                        ready <= 1'b0;
                        state <= s_load;
                    end else begin
                        state <= s_idle;
                    end
                end
                default: state <= s_idle;
            endcase
        end
    end
endmodule

// File: tb/tb_polynomial_evaluate.sv
// tb_polynomial_evaluate: directed vectors for polynomial_evaluate
// (9-point instance) plus a 1-coefficient, 4-point instance.

`ifndef F_NBITS
`define F_NBITS 61
`endif
`ifndef F_PRIME
`define F_PRIME 61'h1FFF_FFFF_FFFF_FFFF
`endif

module tb_polynomial_evaluate;
    localparam int nb = `F_NBITS;
    localparam logic [nb-1:0] p = `F_PRIME;
    localparam longint unsigned pl = 64'(p);
    localparam longint unsigned h = 64'h1000_0000_0000_0000;

    typedef longint unsigned arr9_t [9];
    typedef struct {
        logic [8:0][nb-1:0] c;
        logic [8:0][nb-1:0] y;
    } vec_t;

    logic                 clk = 1'b0;
    logic                 rstb;
    logic                 en;
    logic                 en1;
    logic [8:0][nb-1:0]   c;
    logic [0:0][nb-1:0]   c1;
    logic                 y_wren;
    logic [nb-1:0]        y_data;
    logic                 ready;
    logic                 ready_pulse;
    logic                 y_wren1;
    logic [nb-1:0]        y_data1;
    logic                 ready1;
    logic                 ready_pulse1;

    int n_cmp = 0;
    int n_bad = 0;
    vec_t tbl [5];

    always #5 clk = ~clk;

    polynomial_evaluate u0 (
        .clk         (clk),
        .rstb        (rstb),
        .en          (en),
        .c           (c),
        .y_wren      (y_wren),
        .y_data      (y_data),
        .ready       (ready),
        .ready_pulse (ready_pulse)
    );

    polynomial_evaluate #(
        .npoints (1),
        .nevals  (4)
    ) u1 (
        .clk         (clk),
        .rstb        (rstb),
        .en          (en1),
        .c           (c1),
        .y_wren      (y_wren1),
        .y_data      (y_data1),
        .ready       (ready1),
        .ready_pulse (ready_pulse1)
    );

    task automatic check(
        input string          nm,
        input longint unsigned act,
        input longint unsigned exp
    );
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic fill(input int i, input arr9_t cv, input arr9_t yv);
        for (int k = 0; k < 9; k++) begin
            tbl[i].c[k] = nb'(cv[k]);
            tbl[i].y[k] = nb'(yv[k]);
        end
    endtask

    task automatic run_vec(input int id, input vec_t v, input bit noisy);
        int  ns;
        int  cyc;
        bit  seen;
        @(negedge clk);
        c  = v.c;
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        check($sformatf("v%0d_ready_drop", id), 64'(ready), 0);
        ns   = 0;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 20000) begin
            if (noisy && !ready) begin
                en = 1'($urandom_range(0, 1));
                for (int k = 0; k < 9; k++)
                    c[k] = nb'({$urandom(), $urandom()});
            end else begin
                en = 1'b0;
            end
            @(negedge clk);
            cyc++;
            if (y_wren) begin
                if (ns < 9)
                    check($sformatf("v%0d_y%0d", id, ns),
                          64'(y_data), 64'(v.y[ns]));
                ns++;
            end
            if (ready_pulse) seen = 1'b1;
        end
        en = 1'b0;
        check($sformatf("v%0d_pulse", id), 64'(seen), 1);
        check($sformatf("v%0d_strobes", id), 64'(ns), 9);
        @(negedge clk);
        check($sformatf("v%0d_idle", id),
              64'({ready, ready_pulse, y_wren}), 64'b100);
    endtask

    initial begin
        int ns;
        int cyc;
        int np;
        int first_ns;
        bit chained;
        rstb = 1'b0;
        en   = 1'b0;
        en1  = 1'b0;
        c    = '0;
        c1   = '0;

        fill(0, '{5, 3, 0, 0, 0, 0, 0, 0, 0},
                '{5, 8, 11, 14, 17, 20, 23, 26, 29});
        fill(1, '{pl - 1, 1, 0, 0, 0, 0, 0, 0, 0},
                '{pl - 1, 0, 1, 2, 3, 4, 5, 6, 7});
        fill(2, '{1, 1, 1, 1, 1, 1, 1, 1, 1},
                '{1, 9, 511, 9841, 87381, 488281,
                  2015539, 6725601, 19173961});
        fill(3, '{pl - 1, pl - 1, pl - 1, pl - 1, pl - 1,
                  pl - 1, pl - 1, pl - 1, pl - 1},
                '{pl - 1, pl - 9, pl - 511, pl - 9841,
                  pl - 87381, pl - 488281, pl - 2015539,
                  pl - 6725601, pl - 19173961});
        fill(4, '{0, 0, 0, 0, 0, 0, 0, 0, h},
                '{0, h, 128, h + 3280, 32768, h + 195312,
                  839808, h + 2882400, 8388608});

        repeat (3) @(negedge clk);
        check("rst_out",
              64'({ready, ready_pulse, y_wren}), 64'b100);
        check("rst_ydata", 64'(y_data), 0);
        rstb = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 64'(ready), 1);

        for (int i = 0; i < 5; i++) run_vec(i, tbl[i], 1'b0);

        run_vec(5, tbl[2], 1'b1);

        @(negedge clk);
        c  = tbl[0].c;
        en = 1'b1;
        @(negedge clk);
        en  = 1'b0;
        ns  = 0;
        cyc = 0;
        while (ns < 3 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (y_wren) begin
                check($sformatf("rst_run_y%0d", ns),
                      64'(y_data), 64'(tbl[0].y[ns]));
                ns++;
            end
        end
        check("rst_reach3", 64'(ns), 3);
        repeat (100) @(negedge clk);
        check("rst_mid_ready", 64'(ready), 0);
        #2 rstb = 1'b0;
        #1;
        check("rst_async_out",
              64'({ready, ready_pulse, y_wren}), 64'b100);
        check("rst_async_ydata", 64'(y_data), 0);
        ns = 0;
        repeat (3) begin
            @(negedge clk);
            if (y_wren || ready_pulse) ns++;
        end
        rstb = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (y_wren || ready_pulse || !ready) ns++;
        end
        check("rst_quiet", 64'(ns), 0);
        run_vec(6, tbl[0], 1'b0);

        @(negedge clk);
        c1[0]    = nb'(7);
        en1      = 1'b1;
        ns       = 0;
        np       = 0;
        cyc      = 0;
        first_ns = -1;
        chained  = 1'b0;
        while (np < 2 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (y_wren1) begin
                if (ns < 8)
                    check($sformatf("n1_y%0d", ns), 64'(y_data1), 7);
                ns++;
            end
            if (ready_pulse1) begin
                np++;
                if (np == 1) begin
                    first_ns = ns;
                    @(negedge clk);
                    cyc++;
                    chained = !ready1;
                    if (y_wren1) ns++;
                end
            end
        end
        en1 = 1'b0;
        check("n1_pulses", 64'(np), 2);
        check("n1_first_run", 64'(first_ns), 4);
        check("n1_strobes", 64'(ns), 8);
        check("n1_chained", 64'(chained), 1);
        repeat (3) @(negedge clk);
        check("n1_idle",
              64'({ready1, ready_pulse1, y_wren1}), 64'b100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
